// File: rtl/shifter_pkg.sv
// Shared opcodes, flag positions and FSM state type for the sequential shift unit.
package shifter_pkg;

  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;
  localparam logic [3:0] OP_ROR = 4'd12;

  localparam int unsigned FLG_S = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  // Anything outside the shift opcodes is a pass-through.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_ROL) || (op == OP_SRL) ||
           (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step: shifts by k (1..STEP) and reports the last bit shifted out.
module shift_step
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [3:0]         opcode,
  input  logic [SHAMT_W-1:0] k,
  input  logic               fill,
  output logic [WIDTH-1:0]   y,
  output logic               carry
);

  logic [2*WIDTH-1:0] left_w;
  logic [2*WIDTH-1:0] right_w;
  logic [WIDTH-1:0]   fill_mask;
  logic [SHAMT_W:0]   k_inv;

  always_comb begin
    // Double-width shifts keep the bit that falls off next to the result.
    left_w    = {{WIDTH{1'b0}}, a} << k;
    right_w   = {a, {WIDTH{1'b0}}} >> k;
    fill_mask = ~({WIDTH{1'b1}} >> k);
    k_inv     = (SHAMT_W + 1)'(WIDTH) - {1'b0, k};
    y         = a;
    carry     = 1'b0;
    case (opcode)
      OP_SLL: begin
        y     = left_w[WIDTH-1:0];
        carry = left_w[WIDTH];
      end
      OP_SRL: begin
        y     = right_w[2*WIDTH-1:WIDTH];
        carry = right_w[WIDTH-1];
      end
      OP_SRA: begin
        y     = right_w[2*WIDTH-1:WIDTH] | (fill ? fill_mask : '0);
        carry = right_w[WIDTH-1];
      end
      OP_ROL:  y = (a << k) | (a >> k_inv);
      OP_ROR:  y = (a >> k) | (a << k_inv);
      default: ;
    endcase
  end

endmodule

// File: rtl/shifter_seq.sv
// Multi-cycle shift/rotate unit: STEP bits per cycle, valid/ready on both sides, abortable.
module shifter_seq
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned STEP    = 1,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_opcode,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [SHAMT_W-1:0] in_d,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [3:0]         out_cond
);

  // Amounts never exceed WIDTH-1, so a STEP of WIDTH is clamped to fit the counter.
  localparam int unsigned      STEP_CAP = (STEP > WIDTH - 1) ? WIDTH - 1 : STEP;
  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP_CAP);

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] remaining;
  logic [3:0]         opcode;
  logic               msb;

  logic [SHAMT_W-1:0] k;
  logic [WIDTH-1:0]   step_y;
  logic               step_c;
  logic               last_step;

  assign k         = (remaining > STEP_K) ? STEP_K : remaining;
  assign last_step = (32'(remaining) <= STEP);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  shift_step #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_shift_step (
    .a     (work),
    .opcode(opcode),
    .k     (k),
    .fill  (msb),
    .y     (step_y),
    .carry (step_c)
  );

  function automatic logic [3:0] cond_of(input logic [WIDTH-1:0] data, input logic c);
    logic [3:0] f;
    f        = '0;
    f[FLG_S] = data[WIDTH-1];
    f[FLG_Z] = (data == '0);
    f[FLG_C] = c;
    f[FLG_V] = 1'b0;
    return f;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      remaining <= '0;
      opcode    <= '0;
      msb       <= 1'b0;
      out_data  <= '0;
      out_cond  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work      <= in_a;
            opcode    <= in_opcode;
            remaining <= in_d;
            msb       <= in_a[WIDTH-1];
            if (!is_shift_op(in_opcode) || (in_d == '0)) begin
              out_data <= in_a;
              out_cond <= cond_of(in_a, 1'b0);
              state    <= HOLD;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            work      <= step_y;
            remaining <= remaining - k;
            if (last_step) begin
              out_data <= step_y;
              out_cond <= cond_of(step_y, step_c);
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (abort || out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_seq.sv
// Runs three shifter_seq instances (STEP 1/4/16) in lockstep against a whole-shift reference model.
module tb_shifter_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_opcode;
  logic [15:0] in_a;
  logic [3:0]  in_d;
  logic        abort;
  logic        out_ready;

  logic        ir [3];
  logic        ov [3];
  logic [15:0] od [3];
  logic [3:0]  oc [3];

  logic [15:0] last_d [3];
  logic [3:0]  last_c [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    shifter_seq #(
      .WIDTH(16),
      .STEP ((g == 0) ? 1 : (g == 1) ? 4 : 16)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (ir[g]),
      .in_opcode(in_opcode),
      .in_a     (in_a),
      .in_d     (in_d),
      .abort    (abort),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .out_data (od[g]),
      .out_cond (oc[g])
    );
  end

  function automatic int step_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 16;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Whole-amount reference: result and flags straight from the operation definitions.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input int d,
                                output logic [15:0] r, output logic [3:0] cond);
    int unsigned       x;
    logic              c;
    logic signed [15:0] sa;
    x  = a;
    c  = 1'b0;
    sa = a;
    r  = a;
    case (op)
      4'd8: begin
        r = 16'(x << d);
        if (d != 0) c = a[16-d];
      end
      4'd9:  if (d != 0) r = 16'((x << d) | (x >> (16 - d)));
      4'd10: begin
        r = a >> d;
        if (d != 0) c = a[d-1];
      end
      4'd11: begin
        r = 16'(sa >>> d);
        if (d != 0) c = a[d-1];
      end
      4'd12: if (d != 0) r = 16'((x >> d) | (x << (16 - d)));
      default: ;
    endcase
    cond = {r[15], (r == 16'h0), c, 1'b0};
  endfunction

  function automatic int latency(input logic [3:0] op, input int d, input int step);
    if (op < 4'd8 || op > 4'd12 || d == 0) return 1;
    return 1 + (d + step - 1) / step;
  endfunction

  task automatic run_txn(input logic [3:0] op, input logic [15:0] a, input int d, input int hold);
    logic [15:0] er;
    logic [3:0]  ec;
    int          lat [3];
    model(op, a, d, er, ec);
    in_opcode = op;
    in_a      = a;
    in_d      = 4'(d);
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = '{0, 0, 0};
    for (int cyc = 1; cyc <= 40; cyc++) begin
      for (int i = 0; i < 3; i++) if (ov[i] && lat[i] == 0) lat[i] = cyc;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      in_a      = 16'($urandom);
      in_opcode = 4'($urandom);
      in_d      = 4'($urandom);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("data%0d op%0d", i, op), 32'(od[i]), 32'(er));
      check($sformatf("cond%0d op%0d", i, op), 32'(oc[i]), 32'(ec));
      check($sformatf("lat%0d op%0d d%0d", i, op, d), lat[i], latency(op, d, step_of(i)));
    end
    for (int h = 0; h < hold; h++) begin
      in_a = 16'($urandom);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("hold_data%0d", i), 32'(od[i]), 32'(er));
        check($sformatf("hold_cond%0d", i), 32'(oc[i]), 32'(ec));
        check($sformatf("hold_ready%0d", i), 32'(ir[i]), 32'(0));
        check($sformatf("hold_valid%0d", i), 32'(ov[i]), 32'(1));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rel_valid%0d", i), 32'(ov[i]), 32'(0));
      check($sformatf("rel_ready%0d", i), 32'(ir[i]), 32'(1));
      last_d[i] = er;
      last_c[i] = ec;
    end
  endtask

  initial begin
    logic [15:0] er;
    logic [3:0]  ec;
    logic [3:0]  op;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_a      = '0;
    in_d      = '0;
    abort     = 1'b0;
    out_ready = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ready%0d", i), 32'(ir[i]), 32'(1));
      check($sformatf("rst_valid%0d", i), 32'(ov[i]), 32'(0));
      check($sformatf("rst_data%0d", i), 32'(od[i]), 32'(0));
      check($sformatf("rst_cond%0d", i), 32'(oc[i]), 32'(0));
    end
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(4'd8,  16'h8001, 1,  3);
    run_txn(4'd11, 16'h8000, 15, 0);
    run_txn(4'd10, 16'h0001, 1,  0);
    run_txn(4'd9,  16'h8001, 4,  0);
    run_txn(4'd12, 16'h0001, 1,  0);
    run_txn(4'd3,  16'h1234, 5,  0);
    run_txn(4'd8,  16'h00FF, 5,  0);
    run_txn(4'd10, 16'hF000, 12, 0);

    // Abort in the 4th SHIFT cycle of the STEP=1 instance; the others are already in HOLD.
    model(4'd8, 16'h1234, 10, er, ec);
    in_opcode = 4'd8;
    in_a      = 16'h1234;
    in_d      = 4'd10;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      check("abort_novalid_pre", 32'(ov[0]), 32'(0));
    end
    abort    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort_valid%0d", i), 32'(ov[i]), 32'(0));
      check($sformatf("abort_ready%0d", i), 32'(ir[i]), 32'(1));
    end
    check("abort_keep_data0", 32'(od[0]), 32'(last_d[0]));
    check("abort_keep_cond0", 32'(oc[0]), 32'(last_c[0]));
    check("abort_data1", 32'(od[1]), 32'(er));
    check("abort_data2", 32'(od[2]), 32'(er));
    @(posedge clk); #1;
    check("abort_idle_stays", 32'(ir[0]), 32'(1));

    // Asynchronous reset mid-SHIFT.
    in_opcode = 4'd8;
    in_a      = 16'hA5A5;
    in_d      = 4'd10;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("arst_ready%0d", i), 32'(ir[i]), 32'(1));
      check($sformatf("arst_valid%0d", i), 32'(ov[i]), 32'(0));
      check($sformatf("arst_data%0d", i), 32'(od[i]), 32'(0));
      check($sformatf("arst_cond%0d", i), 32'(oc[i]), 32'(0));
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 5) == 0) op = 4'($urandom_range(0, 7));
      else op = 4'(8 + $urandom_range(0, 4));
      run_txn(op, 16'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shifter_seq.md
Name: shifter_seq

Overview:
- Parametrised, multi-cycle successor to the 16-bit combinational shift unit of the SIMPLE datapath.
- Shifts a WIDTH-bit operand by up to WIDTH-1 bits, STEP bits per clock, behind valid/ready handshakes.
- Produces S/Z/C/V condition codes in the ISA order.
- Adds rotate-right, backpressure and abort, none of which the current unit supports.
- Sits between the register-read stage and the writeback/flag mux.

Parameters:
- WIDTH, 16: operand and result width; must be ≥2.
- STEP, 1: bits shifted per SHIFT cycle; must be a power of two with 1 ≤ STEP ≤ WIDTH. STEP=WIDTH gives single-cycle operation.
- SHAMT_W, $clog2(WIDTH): width of the shift amount.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_opcode  in  4  operation code (see Behaviour).
- in_a  in  WIDTH  operand.
- in_d  in  SHAMT_W  shift amount.
- abort  in  1  synchronous cancel of the current operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_cond  out  4  flags: [3]=S, [2]=Z, [1]=C, [0]=V.

Behaviour:
- Clocking: one clock domain, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_cond=0, all internal registers 0.
- Opcodes:
  - 8 SLL: logical left.
  - 9 ROL: rotate left.
  - 10 SRL: logical right.
  - 11 SRA: arithmetic right, MSB replicated.
  - 12 ROR: rotate right (new).
  - Any other opcode: pass-through; out_data=in_a with zero shift cycles.
- States: IDLE, SHIFT, HOLD.
  - in_ready = (state==IDLE).
  - out_valid = (state==HOLD).
- IDLE: when in_valid=1, latch in_a, in_opcode and in_d, and set remaining=in_d.
  - If the effective amount is 0 (d==0 or pass-through opcode), go to HOLD.
  - Otherwise go to SHIFT.
- SHIFT: each cycle, shift the working register by k=min(STEP, remaining) and subtract k from remaining.
  - When remaining≤STEP at the clock edge, go to HOLD with the final result and flags registered.
  - SHIFT therefore lasts ceil(d/STEP) cycles.
- Latency from accept edge to out_valid high:
  - 1 cycle for d==0.
  - 1+ceil(d/STEP) cycles otherwise.
- HOLD: out_data and out_cond stay stable while out_valid=1 and out_ready=0.
  - out_ready=1 → IDLE at the next edge.
  - in_ready is high the following cycle; there is no same-cycle accept on release.
- Flags, computed on the final result:
  - S = out_data[WIDTH-1].
  - Z = (out_data == 0), compared over the full WIDTH bits.
  - C = last bit shifted out:
    - SLL: original bit WIDTH-d.
    - SRL/SRA: original bit d-1.
    - C=0 when d==0, for ROL/ROR, and for pass-through.
  - V = 0 always.
- Width rules: in_d is interpreted unsigned, 0..WIDTH-1. SRA fills with the latched original MSB, not the current working MSB.
- abort=1 in SHIFT or HOLD → IDLE at the next edge.
  - out_valid drops.
  - out_data and out_cond keep their last value.
  - abort in IDLE has no effect.
  - abort has priority over out_ready and over SHIFT completion.
- A simultaneous in_valid in the abort cycle is not accepted, because in_ready is already low.
- rst asserted mid-operation forces the reset values immediately, regardless of clk. The in-flight result is discarded.
- in_* inputs are ignored outside IDLE. Latched operands are immune to input changes during SHIFT and HOLD.

Decomposition:
- shifter_pkg holds:
  - opcode constants OP_SLL=4'd8, OP_ROL=4'd9, OP_SRL=4'd10, OP_SRA=4'd11, OP_ROR=4'd12;
  - flag index constants FLG_S=3, FLG_Z=2, FLG_C=1, FLG_V=0;
  - the state enum state_t {IDLE, SHIFT, HOLD}.
- One combinational sub-module, shift_step, is natural. It shifts a WIDTH-bit value by k∈[1,STEP] for a given opcode and returns the shifted value and the carry-out bit. shifter_seq holds the FSM, counters and registers.

Test Plan:
- WIDTH=16, STEP=1, SLL, a=0x8001, d=1 → out_data=0x0002, out_cond=4'b0010 (C=1), out_valid 2 cycles after accept.
- SRA, a=0x8000, d=15 → 0xFFFF, S=1, Z=0, C=0, latency 16. Then SRL, a=0x0001, d=1 → 0x0000, Z=1, C=1.
- ROL, a=0x8001, d=4 → 0x0018, C=0. ROR, a=0x0001, d=1 → 0x8000, S=1, C=0. Opcode 3 with a=0x1234 → 0x1234, latency 1, C=0.
- STEP=4, SLL, a=0x00FF, d=5 → 0x1FE0, C=0, exactly 2 SHIFT cycles (latency 3). STEP=16, SRL, a=0xF000, d=12 → 0x000F, C=0, latency 2.
- Backpressure: hold out_ready=0 for 3 cycles in HOLD → out_data/out_cond stable, in_ready=0. Then out_ready=1 → out_valid=0 next cycle and in_ready=1.
- SLL, d=10, STEP=1: assert abort in the 4th SHIFT cycle → IDLE next edge, no out_valid. Assert rst asynchronously mid-SHIFT → outputs at reset values without waiting for a clk edge.
